div64x32_seq: RTL and testbench

- Iterative restoring divider: 64-bit dividend by 32-bit divisor, giving a 32-bit quotient and a 32-bit remainder.
- Inverse companion to mult32x32_fast, with the same start/busy handshake.
- Sits beside the multiplier in the arithmetic unit. Feeding it a multiplier product and one operand recovers the other operand.

---
 rtl/div_pkg.sv | 10 +
 rtl/div_step.sv | 20 ++
 rtl/div64x32_seq.sv | 119 +++++++++++
 tb/tb_div64x32_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and widths for the sequential 64/32 restoring divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, OVF} state_t;

  localparam int DIVIDEND_W = 64;
  localparam int DIVISOR_W  = 32;
  localparam int CNT_W      = $clog2(DIVISOR_W) + 1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, conditionally subtract.
module div_step
  import div_pkg::*;
(
  input  logic [DIVISOR_W:0]   i_rem,
  input  logic                 i_bit,
  input  logic [DIVISOR_W-1:0] i_divisor,
  output logic [DIVISOR_W:0]   o_rem,
  output logic                 o_qBit
);

  logic [DIVISOR_W:0] w_trial;

  assign w_trial = {i_rem[DIVISOR_W-1:0], i_bit};

  // A set top bit of i_rem means the shifted value exceeds any divisor; the modulo-2^33 subtract is still exact.
  assign o_qBit = i_rem[DIVISOR_W] | (w_trial >= {1'b0, i_divisor});
  assign o_rem  = o_qBit ? (w_trial - {1'b0, i_divisor}) : w_trial;

endmodule

// File: rtl/div64x32_seq.sv
// Iterative 64/32 restoring divider with start/busy handshake and STEPS_PER_CYCLE quotient bits per clock.
module div64x32_seq
  import div_pkg::*;
#(
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVISOR_W-1:0]  quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  ovf
);

  if (!(STEPS_PER_CYCLE == 1 || STEPS_PER_CYCLE == 2 || STEPS_PER_CYCLE == 4)) begin : gBadSteps
    $fatal(1, "div64x32_seq: STEPS_PER_CYCLE must be 1, 2 or 4");
  end

  state_t               r_state;
  logic [DIVISOR_W-1:0] r_divisor;
  logic [DIVISOR_W:0]   r_rem;
  logic [DIVISOR_W-1:0] r_shift;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic [DIVISOR_W-1:0] r_quotient;
  logic [DIVISOR_W-1:0] r_remainder;
  logic                 r_ovf;

  logic [DIVISOR_W:0]   w_rem [STEPS_PER_CYCLE+1];
  logic [DIVISOR_W-1:0] w_sh  [STEPS_PER_CYCLE+1];
  logic                 w_qBit [STEPS_PER_CYCLE];
  logic [CNT_W-1:0]     w_cntNext;
  logic                 w_ovfReq;

  // r_shift feeds dividend bits out of its MSB while quotient bits enter at its LSB.
  assign w_rem[0] = r_rem;
  assign w_sh[0]  = r_shift;

  for (genvar k = 0; k < STEPS_PER_CYCLE; k++) begin : gStep
    div_step uStep (
      .i_rem     (w_rem[k]),
      .i_bit     (w_sh[k][DIVISOR_W-1]),
      .i_divisor (r_divisor),
      .o_rem     (w_rem[k+1]),
      .o_qBit    (w_qBit[k])
    );
    assign w_sh[k+1] = {w_sh[k][DIVISOR_W-2:0], w_qBit[k]};
  end

  assign w_cntNext = r_cnt + CNT_W'(STEPS_PER_CYCLE);
  assign w_ovfReq  = dividend[DIVIDEND_W-1:DIVISOR_W] >= divisor;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_divisor   <= '0;
      r_rem       <= '0;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (w_ovfReq) begin
              r_state <= OVF;
            end else begin
              r_state   <= RUN;
              r_divisor <= divisor;
              r_rem     <= {1'b0, dividend[DIVIDEND_W-1:DIVISOR_W]};
              r_shift   <= dividend[DIVISOR_W-1:0];
              r_cnt     <= '0;
            end
          end
        end
        RUN: begin
          r_rem   <= w_rem[STEPS_PER_CYCLE];
          r_shift <= w_sh[STEPS_PER_CYCLE];
          r_cnt   <= w_cntNext;
          if (w_cntNext == CNT_W'(DIVISOR_W)) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_quotient  <= w_sh[STEPS_PER_CYCLE];
            r_remainder <= w_rem[STEPS_PER_CYCLE][DIVISOR_W-1:0];
            r_ovf       <= 1'b0;
          end
        end
        OVF: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_done      <= 1'b1;
          r_quotient  <= '1;
          r_remainder <= '0;
          r_ovf       <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_div64x32_seq.sv
// Self-checking bench: two divider instances (1 and 4 steps per cycle) against a plain-arithmetic model.
module tb_div64x32_seq;

  logic        clk = 1'b0;
  logic        resetN    [2];
  logic        start     [2];
  logic [63:0] dividend  [2];
  logic [31:0] divisor   [2];
  logic        busy      [2];
  logic        done      [2];
  logic [31:0] quotient  [2];
  logic [31:0] remainder [2];
  logic        ovf       [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div64x32_seq #(.STEPS_PER_CYCLE(1)) dut1 (
    .clk(clk), .reset(resetN[0]), .start(start[0]), .dividend(dividend[0]),
    .divisor(divisor[0]), .busy(busy[0]), .done(done[0]),
    .quotient(quotient[0]), .remainder(remainder[0]), .ovf(ovf[0])
  );

  div64x32_seq #(.STEPS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(resetN[1]), .start(start[1]), .dividend(dividend[1]),
    .divisor(divisor[1]), .busy(busy[1]), .done(done[1]),
    .quotient(quotient[1]), .remainder(remainder[1]), .ovf(ovf[1])
  );

  function automatic int stepsOf(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // Reference: {ovf, quotient, remainder} from ordinary 64-bit division.
  function automatic logic [64:0] refDiv(input logic [63:0] dvd, input logic [31:0] dvs);
    logic [63:0] q64;
    logic [63:0] r64;
    if (dvs == 32'd0) return {1'b1, 32'hFFFF_FFFF, 32'h0};
    q64 = dvd / {32'h0, dvs};
    r64 = dvd % {32'h0, dvs};
    if (q64 > 64'h0000_0000_FFFF_FFFF) return {1'b1, 32'hFFFF_FFFF, 32'h0};
    return {1'b0, q64[31:0], r64[31:0]};
  endfunction

  function automatic int refBusy(input logic [64:0] res, input int d);
    return res[64] ? 1 : 32 / stepsOf(d);
  endfunction

  // Issues one operation and observes busy length and done pulses; start may be pulsed mid-run at pulseAt.
  task automatic runOp(input int d, input logic [63:0] dvd, input logic [31:0] dvs, input int pulseAt,
                       output int busyCyc, output int doneCnt);
    @(negedge clk);
    start[d] = 1'b1; dividend[d] = dvd; divisor[d] = dvs;
    @(negedge clk);
    start[d] = 1'b0; dividend[d] = {$urandom, $urandom}; divisor[d] = $urandom;
    busyCyc = 0;
    doneCnt = 0;
    for (int i = 0; i < 64; i++) begin
      if (done[d]) doneCnt++;
      if (!busy[d]) break;
      busyCyc++;
      if (i == pulseAt) begin
        start[d] = 1'b1; divisor[d] = 32'd3; dividend[d] = 64'd100;
      end else begin
        start[d] = 1'b0;
      end
      @(negedge clk);
    end
    start[d] = 1'b0;
    @(negedge clk);
    if (done[d]) doneCnt++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({busy[d], done[d], quotient[d], remainder[d], ovf[d]} !== 67'd0) begin
        errors++;
        $display("[TB] FAIL reset_state dut%0d: got busy=%b done=%b q=%h r=%h ovf=%b, want all zero",
                 d, busy[d], done[d], quotient[d], remainder[d], ovf[d]);
      end
    end
    resetN[0] = 1'b1;
    resetN[1] = 1'b1;
  endtask

  task automatic test_fixed(input string name, input logic [63:0] dvd, input logic [31:0] dvs,
                            input logic [64:0] want, input int pulseAt);
    int b, n;
    for (int d = 0; d < 2; d++) begin
      runOp(d, dvd, dvs, pulseAt, b, n);
      checks++;
      if ({ovf[d], quotient[d], remainder[d]} !== want) begin
        errors++;
        $display("[TB] FAIL %s_result dut%0d: got ovf=%b q=%h r=%h, want ovf=%b q=%h r=%h",
                 name, d, ovf[d], quotient[d], remainder[d], want[64], want[63:32], want[31:0]);
      end
      checks++;
      if (b !== refBusy(want, d)) begin
        errors++;
        $display("[TB] FAIL %s_busy dut%0d: got %0d cycles, want %0d", name, d, b, refBusy(want, d));
      end
      checks++;
      if (n !== 1) begin
        errors++;
        $display("[TB] FAIL %s_done dut%0d: got %0d pulses, want 1", name, d, n);
      end
    end
  endtask

  task automatic test_roundtrip();
    test_fixed("roundtrip", 64'd65690688518499791, 32'd318947199, {1'b0, 32'd205961014, 32'd5}, -1);
  endtask

  task automatic test_overflow();
    test_fixed("divzero", 64'd5, 32'd0, {1'b1, 32'hFFFF_FFFF, 32'h0}, -1);
    test_fixed("ovf_hi", 64'h0000_0002_0000_0000, 32'd2, {1'b1, 32'hFFFF_FFFF, 32'h0}, -1);
  endtask

  task automatic test_boundary();
    test_fixed("boundary", 64'hFFFF_FFFE_FFFF_FFFF, 32'hFFFF_FFFF, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE}, -1);
  endtask

  task automatic test_ignored_start();
    test_fixed("ignored_start", 64'd65690688518499791, 32'd318947199, {1'b0, 32'd205961014, 32'd5}, 3);
  endtask

  task automatic test_back_to_back();
    bit seen;
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      start[d] = 1'b1; dividend[d] = 64'd100; divisor[d] = 32'd7;
      @(negedge clk);
      start[d] = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 64 && !seen; i++) begin
        if (done[d]) seen = 1'b1;
        else @(negedge clk);
      end
      checks++;
      if (!seen || {ovf[d], quotient[d], remainder[d]} !== {1'b0, 32'd14, 32'd2}) begin
        errors++;
        $display("[TB] FAIL b2b_first dut%0d: done=%b q=%0d r=%0d ovf=%b, want done q=14 r=2 ovf=0",
                 d, seen, quotient[d], remainder[d], ovf[d]);
      end
      start[d] = 1'b1; dividend[d] = 64'd7; divisor[d] = 32'd100;
      @(negedge clk);
      start[d] = 1'b0;
      checks++;
      if (busy[d] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b2b_accept dut%0d: got busy=%b, want 1", d, busy[d]);
      end
      seen = 1'b0;
      for (int i = 0; i < 64 && !seen; i++) begin
        if (done[d]) seen = 1'b1;
        else @(negedge clk);
      end
      checks++;
      if (!seen || {ovf[d], quotient[d], remainder[d]} !== {1'b0, 32'd0, 32'd7}) begin
        errors++;
        $display("[TB] FAIL b2b_second dut%0d: done=%b q=%0d r=%0d ovf=%b, want done q=0 r=7 ovf=0",
                 d, seen, quotient[d], remainder[d], ovf[d]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int b, n;
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      start[d] = 1'b1; dividend[d] = 64'd65690688518499791; divisor[d] = 32'd318947199;
      @(negedge clk);
      start[d] = 1'b0;
      repeat ((d == 0) ? 10 : 3) @(negedge clk);
      resetN[d] = 1'b0;
      #2;
      checks++;
      if ({busy[d], done[d], quotient[d], remainder[d], ovf[d]} !== 67'd0) begin
        errors++;
        $display("[TB] FAIL reset_mid dut%0d: got busy=%b done=%b q=%h r=%h ovf=%b, want all zero",
                 d, busy[d], done[d], quotient[d], remainder[d], ovf[d]);
      end
      @(negedge clk);
      resetN[d] = 1'b1;
      runOp(d, 64'd100, 32'd7, -1, b, n);
      checks++;
      if ({ovf[d], quotient[d], remainder[d]} !== {1'b0, 32'd14, 32'd2} || b !== 32 / stepsOf(d)) begin
        errors++;
        $display("[TB] FAIL reset_recover dut%0d: got q=%0d r=%0d ovf=%b busy=%0d, want q=14 r=2 ovf=0 busy=%0d",
                 d, quotient[d], remainder[d], ovf[d], b, 32 / stepsOf(d));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] dvs, hi;
    logic [63:0] dvd;
    logic [64:0] want;
    int b, n, d;
    for (int k = 0; k < 40; k++) begin
      d = k % 2;
      dvs = $urandom;
      if ($urandom_range(0, 9) == 0) dvs = 32'd0;
      if ($urandom_range(0, 4) == 0 || dvs == 32'd0) hi = $urandom;
      else hi = $urandom % dvs;
      dvd = {hi, 32'($urandom)};
      want = refDiv(dvd, dvs);
      runOp(d, dvd, dvs, -1, b, n);
      checks++;
      if ({ovf[d], quotient[d], remainder[d]} !== want || b !== refBusy(want, d) || n !== 1) begin
        errors++;
        $display("[TB] FAIL random dut%0d %h/%h: got ovf=%b q=%h r=%h busy=%0d done=%0d, want ovf=%b q=%h r=%h busy=%0d done=1",
                 d, dvd, dvs, ovf[d], quotient[d], remainder[d], b, n,
                 want[64], want[63:32], want[31:0], refBusy(want, d));
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      resetN[d] = 1'b0; start[d] = 1'b0; dividend[d] = '0; divisor[d] = '0;
    end
    test_reset();
    test_roundtrip();
    test_back_to_back();
    test_overflow();
    test_boundary();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
